// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared state, class codes and IEEE-754 constants for the divider back end
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_DENORM,
        ST_ROUND,
        ST_DONE
    } fp_state_t;

    localparam logic [1:0] FP_CLS_NORM = 2'b00;
    localparam logic [1:0] FP_CLS_ZERO = 2'b01;
    localparam logic [1:0] FP_CLS_INF  = 2'b10;
    localparam logic [1:0] FP_CLS_NAN  = 2'b11;

    localparam int          FP_BIAS       = 127;
    localparam int          FP_EMAX       = 255;
    localparam int          FP_DENORM_MAX = 26;
    localparam logic [31:0] FP_QNAN       = 32'h7FC00000;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even on a 24-bit mantissa with guard and sticky
module fp_round_rne (
    input  logic [23:0] mant_in,
    input  logic        guard,
    input  logic        sticky,
    output logic [23:0] mant_out,
    output logic        carry,
    output logic        inexact
);

    logic round_up;

    assign round_up            = guard & (sticky | mant_in[0]);
    assign {carry, mant_out}   = {1'b0, mant_in} + {24'd0, round_up};
    assign inexact             = guard | sticky;

endmodule

// File: rtl/fp_div_norm_round.sv
// rtl/fp_div_norm_round.sv - divider quotient normalise/round/pack stage; FP_SUBNORMAL_EN enables gradual underflow
module fp_div_norm_round
    import fp_pkg::*;
#(
    parameter int QW    = 32,
    parameter int EXP_W = 10
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [QW-1:0]           quo,
    input  logic signed [EXP_W-1:0] exp_in,
    input  logic                    sign_in,
    input  logic [1:0]              cls_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             result,
    output logic                    ovf,
    output logic                    unf,
    output logic                    inexact
);

    localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] E_ZERO = '0;
    localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(FP_EMAX);

    fp_state_t              state;
    logic [QW-1:0]          q_r;
    logic signed [EXP_W-1:0] e_r;
    logic                   s_r;
    logic [1:0]             cls_r;

    logic signed [EXP_W-1:0] e_norm;
    logic signed [EXP_W-1:0] e_rnd;
    logic [23:0]            mant_raw;
    logic [23:0]            mant_rnd;
    logic                   guard;
    logic                   sticky;
    logic                   rnd_carry;
    logic                   rnd_inexact;

    logic [31:0]            res_n;
    logic                   ovf_n;
    logic                   unf_n;
    logic                   inx_n;

`ifdef FP_SUBNORMAL_EN
    localparam logic signed [EXP_W-1:0] E_DMAX = EXP_W'(FP_DENORM_MAX);

    logic                    stk_r;
    logic                    tiny_r;
    logic [4:0]              cnt_r;
    logic signed [EXP_W-1:0] sh;

    assign sh     = E_ONE - e_norm;
    assign sticky = (|q_r[QW-26:0]) | stk_r;
`else
    logic unused_hidden;

    assign unused_hidden = mant_rnd[23];
    assign sticky        = |q_r[QW-26:0];
`endif

    assign in_ready = (state == ST_IDLE);
    assign e_norm   = q_r[QW-1] ? e_r : e_r - E_ONE;
    assign mant_raw = q_r[QW-1 -: 24];
    assign guard    = q_r[QW-25];

    fp_round_rne u_rnd (
        .mant_in  (mant_raw),
        .guard    (guard),
        .sticky   (sticky),
        .mant_out (mant_rnd),
        .carry    (rnd_carry),
        .inexact  (rnd_inexact)
    );

    // A rounding carry leaves mant_rnd at zero, which is exactly the fraction of 1.0.
    assign e_rnd = rnd_carry ? e_r + E_ONE : e_r;

    always_comb begin
        res_n = '0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        inx_n = 1'b0;
        case (cls_r)
            FP_CLS_ZERO: res_n = {s_r, 31'd0};
            FP_CLS_INF:  res_n = {s_r, 8'hFF, 23'd0};
            FP_CLS_NAN:  res_n = FP_QNAN;
            default: begin
`ifdef FP_SUBNORMAL_EN
                if (tiny_r) begin
                    res_n = {s_r, 7'd0, mant_rnd[23], mant_rnd[22:0]};
                    unf_n = rnd_inexact;
                    inx_n = rnd_inexact;
                end else
`endif
                if (e_rnd >= E_MAX) begin
                    res_n = {s_r, 8'hFF, 23'd0};
                    ovf_n = 1'b1;
                    inx_n = 1'b1;
                end else if (e_rnd <= E_ZERO) begin
                    res_n = {s_r, 31'd0};
                    unf_n = 1'b1;
                    inx_n = 1'b1;
                end else begin
                    res_n = {s_r, e_rnd[7:0], mant_rnd[22:0]};
                    inx_n = rnd_inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            q_r       <= '0;
            e_r       <= '0;
            s_r       <= 1'b0;
            cls_r     <= FP_CLS_NORM;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inexact   <= 1'b0;
            out_valid <= 1'b0;
`ifdef FP_SUBNORMAL_EN
            stk_r     <= 1'b0;
            tiny_r    <= 1'b0;
            cnt_r     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        q_r   <= quo;
                        e_r   <= exp_in;
                        s_r   <= sign_in;
                        cls_r <= cls_in;
`ifdef FP_SUBNORMAL_EN
                        stk_r  <= 1'b0;
                        tiny_r <= 1'b0;
`endif
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    q_r   <= q_r[QW-1] ? q_r : q_r << 1;
                    e_r   <= e_norm;
                    state <= ST_ROUND;
`ifdef FP_SUBNORMAL_EN
                    if (cls_r == FP_CLS_NORM && e_norm <= E_ZERO) begin
                        tiny_r <= 1'b1;
                        cnt_r  <= (sh > E_DMAX) ? 5'(FP_DENORM_MAX) : sh[4:0];
                        state  <= ST_DENORM;
                    end
`endif
                end
`ifdef FP_SUBNORMAL_EN
                ST_DENORM: begin
                    q_r   <= q_r >> 1;
                    stk_r <= stk_r | q_r[0];
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r == 5'd1)
                        state <= ST_ROUND;
                end
`endif
                ST_ROUND: begin
                    result    <= res_n;
                    ovf       <= ovf_n;
                    unf       <= unf_n;
                    inexact   <= inx_n;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
